vid_line_prefetch: RTL and testbench
====================================

# vid_line_prefetch

Video line prefetcher sitting directly upstream of the SDRAM controller's video read port. On command from the video timing logic it issues a run of 32-bit burst reads (two 16-bit words each), assembles the returned words into one bank of a double-buffered line buffer, and serves bytes from the other bank to the pixel pipeline with one-cycle latency. This lets the whole next scanline be fetched during the current one.

## Interface
Parameters:
- LINE_PAIRS, 40, capacity of each bank in 32-bit pairs (40 = 160 bytes, widest CoCo3 line)

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- init  in  1  synchronous, active-high reset
- fetch_go  in  1  one-cycle pulse that starts a line fetch
- fetch_addr  in  25  byte start address in SDRAM; bit 0 ignored (treated as 0)
- fetch_pairs  in  6  number of 32-bit pairs to fetch; clamped to LINE_PAIRS; 0 = empty fetch
- fetch_busy  out  1  high while a fetch is in progress
- fetch_done  out  1  one-cycle pulse when the last word of a fetch is stored
- swap  in  1  one-cycle pulse that toggles which bank is displayed
- rd_addr  in  8  byte index into the display bank
- rd_data  out  8  registered byte read from the display bank
- sdram_vid_addr  out  25  read address to controller
- sdram_vid_req  out  1  read request to controller
- sdram_vid_ack  in  1  controller has issued the read command
- sdram_vid_ready  in  1  sdram_dout holds a valid read word this cycle
- sdram_dout  in  16  controller read data

## Operation
- Banks: bank0 and bank1, each 2*LINE_PAIRS 16-bit words. disp_bank selects the bank read by rd_addr. fill_bank = ~disp_bank, latched at fetch_go.
- Byte order: even byte index = word[7:0], odd = word[15:8]. This matches the controller's DQM mapping.
- FSM states: IDLE, REQ, DATA0, DATA1.
  - IDLE, fetch_go with fetch_pairs != 0: latch address (A0 = 0), remaining count, and fill_bank; word index = 0; go to REQ.
  - IDLE, fetch_go with fetch_pairs == 0: fetch_done pulses the next cycle. fetch_busy never rises.
  - REQ: request held. When sdram_vid_ack = 1, go to DATA0.
  - DATA0: on sdram_vid_ready, store sdram_dout at word index, increment the index, go to DATA1.
  - DATA1: on sdram_vid_ready, store the word, increment the index, add 4 to the address, decrement the remaining count.
    - Count now 0: go to IDLE and pulse fetch_done.
    - Otherwise: go to REQ.
- Request gating: sdram_vid_req = (state == REQ) & ~sdram_vid_ack. It is combinational, so the request drops in the same cycle ack is seen. The controller re-samples the request the cycle after ack, and this gating prevents a duplicate read.
- sdram_vid_addr holds the current pair address whenever state is REQ. Its value is don't-care otherwise.
- Ignored inputs:
  - sdram_vid_ready in IDLE or REQ is ignored (stray or post-reset data).
  - fetch_go while fetch_busy is ignored.
- swap toggles disp_bank at any time. A fetch in progress keeps writing its latched fill_bank.
- rd_data <= byte at rd_addr of disp_bank each cycle. When rd_addr >= 4*LINE_PAIRS, rd_data <= 8'h00.
- Arithmetic: the address adds 4 per pair, modulo 2^25. The word index is 7 bits.

## Timing
- Reset values: state IDLE, disp_bank 0, fetch_busy 0, fetch_done 0, sdram_vid_req 0, sdram_vid_addr 0, rd_data 8'h00. Buffer contents are not cleared.
- fetch_go at cycle t:
  - state = REQ, fetch_busy = 1, and sdram_vid_req = 1 at t+1.
  - fetch_busy falls in the same cycle fetch_done pulses.
- Minimum cycles per pair: ack cycle, then two ready cycles. Ready pulses may arrive on consecutive cycles and must both be captured.
- Next request is asserted the cycle after the second ready of the previous pair.
- Read latency: rd_data reflects rd_addr and disp_bank as sampled one edge earlier.
- swap and a read in the same cycle: the read uses the pre-toggle bank, and the new bank applies from the next cycle.
- init mid-fetch: the request drops the next cycle and the FSM returns to IDLE. Outstanding ready pulses are ignored. Partially written bank contents are left as they are.

## Test plan
- Basic fetch:
  - Stimulus: fetch_go, addr 0x000100, pairs 2; controller model returns 0xA1B2, 0xC3D4, 0xE5F6, 0x0718; then swap.
  - Required: addresses 0x000100 then 0x000104; fetch_done after the 4th ready; rd_addr 0..7 gives B2 A1 D4 C3 F6 E5 18 07.
- Request gating:
  - Stimulus: controller holds ack high for 3 cycles after issuing the read.
  - Required: sdram_vid_req low the whole time ack is high; exactly one read issued per pair.
- Empty and odd address:
  - Stimulus 1: pairs = 0. Required: fetch_done pulse, busy stays 0, no request.
  - Stimulus 2: addr 0x000101. Required: sdram_vid_addr = 0x000100.
- Double buffering:
  - Stimulus: display bank0 holding line X; fetch line Y into bank1 while reading bank0; swap mid-fetch.
  - Required: bank0 reads stay X until the swap; Y completes in bank1, readable after the swap.
- Clamp and busy:
  - Stimulus 1: pairs = 63 with LINE_PAIRS = 40. Required: exactly 40 requests.
  - Stimulus 2: second fetch_go while busy. Required: ignored.
- Reset mid-fetch:
  - Stimulus: init asserted between DATA0 and DATA1; stray ready arrives afterwards.
  - Required: req 0, busy 0, stray ready ignored; a new fetch then completes normally.

Source files
------------

// File: rtl/vid_line_prefetch.sv
// rtl/vid_line_prefetch.sv - double-buffered video line prefetcher on the SDRAM video read port
//
// Purpose:
//   Fetches a scanline from SDRAM as a run of 32-bit pairs (two 16-bit reads
//   each) into the fill bank of a two-bank line buffer. At the same time it
//   serves bytes from the display bank to the pixel pipeline with one cycle of
//   latency. swap flips the roles of the two banks.
//
// Parameters:
//   LINE_PAIRS        capacity of each bank in 32-bit pairs (1..63)
//
// Ports:
//   i_clk             system clock, shared with the SDRAM controller
//   i_init            synchronous active-high reset
//   i_fetch_go        one-cycle pulse that starts a line fetch (ignored while busy)
//   i_fetch_addr      byte start address; bit 0 is forced to 0
//   i_fetch_pairs     pairs to fetch, clamped to LINE_PAIRS; 0 = empty fetch
//   o_fetch_busy      fetch in progress
//   o_fetch_done      one-cycle pulse when the last word has been stored
//   i_swap            one-cycle pulse that toggles the display bank
//   i_rd_addr         byte index into the display bank
//   o_rd_data         registered byte read
//   o_sdram_vid_addr  pair read address (meaningful while requesting)
//   o_sdram_vid_req   read request
//   i_sdram_vid_ack   controller has issued the read command
//   i_sdram_vid_ready i_sdram_dout holds a valid read word
//   i_sdram_dout      controller read data
module vid_line_prefetch #(
  parameter int LINE_PAIRS = 40
) (
  input  logic        i_clk,
  input  logic        i_init,
  input  logic        i_fetch_go,
  input  logic [24:0] i_fetch_addr,
  input  logic [5:0]  i_fetch_pairs,
  output logic        o_fetch_busy,
  output logic        o_fetch_done,
  input  logic        i_swap,
  input  logic [7:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  output logic [24:0] o_sdram_vid_addr,
  output logic        o_sdram_vid_req,
  input  logic        i_sdram_vid_ack,
  input  logic        i_sdram_vid_ready,
  input  logic [15:0] i_sdram_dout
);

  localparam int         WORDS     = 2 * LINE_PAIRS;
  localparam logic [5:0] PAIRS_MAX = (LINE_PAIRS > 63) ? 6'd63 : 6'(LINE_PAIRS);
  localparam logic [6:0] WORDS_W   = 7'(WORDS);
  localparam logic [8:0] BYTES_W   = 9'(4 * LINE_PAIRS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA0,
    ST_DATA1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [24:0] r_addr;
  logic [5:0]  r_remaining;
  logic [6:0]  r_word_idx;
  logic        r_fill_bank;
  logic        r_disp_bank;
  logic        r_done;
  logic [7:0]  r_rd_data;

  logic [15:0] r_bank0 [0:WORDS-1];
  logic [15:0] r_bank1 [0:WORDS-1];

  logic        w_done_next;
  logic        w_start;
  logic        w_store;
  logic        w_pair_end;
  logic [5:0]  w_pairs;
  logic [15:0] w_rd_word;
  logic [7:0]  w_rd_byte;

  // Requests longer than a bank are truncated to one bank's worth.
  always_comb begin
    w_pairs = (i_fetch_pairs > PAIRS_MAX) ? PAIRS_MAX : i_fetch_pairs;
  end

  // Next-state and strobes. Ready is only honoured in the data states, so
  // stray words after reset or before the command is acked are dropped.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_start      = 1'b0;
    w_store      = 1'b0;
    w_pair_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_fetch_go) begin
          if (w_pairs == 6'd0) begin
            w_done_next = 1'b1;
          end else begin
            w_start      = 1'b1;
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_sdram_vid_ack) begin
          w_state_next = ST_DATA0;
        end
      end
      ST_DATA0: begin
        if (i_sdram_vid_ready) begin
          w_store      = 1'b1;
          w_state_next = ST_DATA1;
        end
      end
      ST_DATA1: begin
        if (i_sdram_vid_ready) begin
          w_store    = 1'b1;
          w_pair_end = 1'b1;
          if (r_remaining == 6'd1) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = ST_REQ;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Fetch datapath. The fill bank is captured at start so a swap during the
  // fetch does not redirect the remaining words.
  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_addr      <= 25'd0;
      r_remaining <= 6'd0;
      r_word_idx  <= 7'd0;
      r_fill_bank <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= i_fetch_addr & ~25'd1;
        r_remaining <= w_pairs;
        r_word_idx  <= 7'd0;
        r_fill_bank <= ~r_disp_bank;
      end
      if (w_store) begin
        r_word_idx <= r_word_idx + 7'd1;
      end
      if (w_pair_end) begin
        r_addr      <= r_addr + 25'd4;
        r_remaining <= r_remaining - 6'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_disp_bank <= 1'b0;
    end else if (i_swap) begin
      r_disp_bank <= ~r_disp_bank;
    end
  end

  // Buffer storage has no reset so it can map onto block RAM; contents
  // survive init.
  always_ff @(posedge i_clk) begin
    if (!i_init && w_store && (r_word_idx < WORDS_W)) begin
      if (r_fill_bank) begin
        r_bank1[r_word_idx] <= i_sdram_dout;
      end else begin
        r_bank0[r_word_idx] <= i_sdram_dout;
      end
    end
  end

  // Even byte index is the low half of the word, matching the DQM lanes.
  always_comb begin
    w_rd_word = r_disp_bank ? r_bank1[i_rd_addr[7:1]] : r_bank0[i_rd_addr[7:1]];
    w_rd_byte = i_rd_addr[0] ? w_rd_word[15:8] : w_rd_word[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_init) begin
      r_rd_data <= 8'h00;
    end else if ({1'b0, i_rd_addr} >= BYTES_W) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd_byte;
    end
  end

  // Request drops combinationally on ack: the controller samples req again
  // in the cycle after ack, and this keeps it from issuing a second read.
  assign o_sdram_vid_req  = (r_state == ST_REQ) & ~i_sdram_vid_ack;
  assign o_sdram_vid_addr = r_addr;
  assign o_fetch_busy     = (r_state != ST_IDLE);
  assign o_fetch_done     = r_done;
  assign o_rd_data        = r_rd_data;

endmodule

// File: tb/tb_vid_line_prefetch.sv
// tb/tb_vid_line_prefetch.sv - self-checking bench for vid_line_prefetch
module tb_vid_line_prefetch;

  localparam int LP = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_init = 1'b1;
  logic        i_fetch_go = 1'b0;
  logic [24:0] i_fetch_addr = 25'd0;
  logic [5:0]  i_fetch_pairs = 6'd0;
  logic        i_swap = 1'b0;
  logic [7:0]  i_rd_addr = 8'd0;
  logic        i_sdram_vid_ack = 1'b0;
  logic        i_sdram_vid_ready = 1'b0;
  logic [15:0] i_sdram_dout = 16'd0;
  logic        o_fetch_busy;
  logic        o_fetch_done;
  logic [7:0]  o_rd_data;
  logic [24:0] o_sdram_vid_addr;
  logic        o_sdram_vid_req;

  vid_line_prefetch #(.LINE_PAIRS(LP)) dut (
    .i_clk             (clk),
    .i_init            (i_init),
    .i_fetch_go        (i_fetch_go),
    .i_fetch_addr      (i_fetch_addr),
    .i_fetch_pairs     (i_fetch_pairs),
    .o_fetch_busy      (o_fetch_busy),
    .o_fetch_done      (o_fetch_done),
    .i_swap            (i_swap),
    .i_rd_addr         (i_rd_addr),
    .o_rd_data         (o_rd_data),
    .o_sdram_vid_addr  (o_sdram_vid_addr),
    .o_sdram_vid_req   (o_sdram_vid_req),
    .i_sdram_vid_ack   (i_sdram_vid_ack),
    .i_sdram_vid_ready (i_sdram_vid_ready),
    .i_sdram_dout      (i_sdram_dout)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: a fetch is a list of pair reads; a request is pending
  // whenever every word of the acked pairs has been stored.
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_disp = 0;
  bit          m_fill = 0;
  bit          m_rd_known = 0;
  logic [7:0]  m_rd = 8'h00;
  int          m_total = 0;
  int          m_acks = 0;
  int          m_stored = 0;
  logic [24:0] m_base = 25'd0;
  logic [15:0] m_bank [2][2*LP];
  bit          m_valid [2][2*LP];

  // Controller model state.
  bit          ctl_req_seen = 0;
  int          ctl_ack_left = 0;
  int          ctl_words_due = 0;
  int          ctl_hold = 1;
  int          ctl_reads = 0;
  int          ctl_dups = 0;
  int          ctl_readies = 0;
  bit          ctl_gaps = 0;
  bit          rd_random = 0;
  bit          swap_random = 0;
  bit          chk_en = 0;
  logic [15:0] ctl_data_q [$];
  logic [24:0] ctl_addr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit pend;
    pend = m_busy && (m_stored == 2 * m_acks);
    check("busy", 32'(o_fetch_busy), 32'(m_busy));
    check("done", 32'(o_fetch_done), 32'(m_done));
    check("req", 32'(o_sdram_vid_req), 32'(pend && !i_sdram_vid_ack));
    if (pend) check("addr", 32'(o_sdram_vid_addr), 32'(25'(m_base + 25'(4 * m_acks))));
    if (m_rd_known) check("rd_data", 32'(o_rd_data), 32'(m_rd));
  endtask

  task automatic model_step();
    int w;
    logic [15:0] word;
    bit nd;
    nd = 0;
    if (i_init) begin
      m_busy = 0; m_disp = 0; m_rd = 8'h00; m_rd_known = 1;
      m_acks = 0; m_stored = 0; m_total = 0; m_done = 0; m_base = 25'd0;
    end else begin
      if (int'(i_rd_addr) >= 4 * LP) begin
        m_rd = 8'h00;
        m_rd_known = 1;
      end else begin
        w = int'(i_rd_addr) / 2;
        word = m_bank[m_disp][w];
        m_rd_known = m_valid[m_disp][w];
        m_rd = (int'(i_rd_addr) % 2 == 1) ? word[15:8] : word[7:0];
      end
      if (m_busy) begin
        if (m_stored == 2 * m_acks) begin
          if (i_sdram_vid_ack) m_acks++;
        end else if (i_sdram_vid_ready) begin
          m_bank[m_fill][m_stored] = i_sdram_dout;
          m_valid[m_fill][m_stored] = 1;
          m_stored++;
          if (m_stored == 2 * m_total) begin
            m_busy = 0;
            nd = 1;
          end
        end
      end else if (i_fetch_go) begin
        m_total = (int'(i_fetch_pairs) > LP) ? LP : int'(i_fetch_pairs);
        if (m_total == 0) begin
          nd = 1;
        end else begin
          m_busy = 1; m_acks = 0; m_stored = 0;
          m_fill = !m_disp;
          m_base = i_fetch_addr & ~25'd1;
        end
      end
      if (i_swap) m_disp = !m_disp;
      m_done = nd;
    end
  endtask

  task automatic ctl_drive();
    i_fetch_go = 1'b0;
    i_swap = 1'b0;
    i_init = 1'b0;
    i_sdram_vid_ack = 1'b0;
    i_sdram_vid_ready = 1'b0;
    i_sdram_dout = 16'($urandom);
    if (rd_random) i_rd_addr = 8'($urandom_range(0, 170));
    if (swap_random && $urandom_range(0, 40) == 0) i_swap = 1'b1;
    if (ctl_req_seen) begin
      if (ctl_ack_left != 0 || ctl_words_due != 0) begin
        ctl_dups++;
      end else begin
        ctl_reads++;
        ctl_ack_left = ctl_hold;
        ctl_words_due = 2;
      end
    end
    if (ctl_ack_left != 0) begin
      i_sdram_vid_ack = 1'b1;
      ctl_ack_left--;
    end else if (ctl_words_due != 0 && (!ctl_gaps || $urandom_range(0, 2) != 0)) begin
      i_sdram_vid_ready = 1'b1;
      ctl_readies++;
      ctl_words_due--;
      if (ctl_data_q.size() != 0) i_sdram_dout = ctl_data_q.pop_front();
    end
  endtask

  // One clock: check at the falling edge, predict the coming rising edge,
  // then drive the next cycle's inputs just after it.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare();
    ctl_req_seen = o_sdram_vid_req;
    if (o_sdram_vid_req) ctl_addr_q.push_back(o_sdram_vid_addr);
    model_step();
    @(posedge clk);
    #1;
    ctl_drive();
  endtask

  task automatic start_fetch(input logic [24:0] addr, input logic [5:0] pairs);
    i_fetch_go = 1'b1;
    i_fetch_addr = addr;
    i_fetch_pairs = pairs;
    tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!o_fetch_done && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(o_fetch_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int d0;
    int k;
    logic [7:0] exp_b [8];

    // Reset.
    i_init = 1'b1;
    tick();
    chk_en = 1;
    i_init = 1'b1;
    tick();
    check("rst_busy", 32'(o_fetch_busy), 32'd0);
    check("rst_done", 32'(o_fetch_done), 32'd0);
    check("rst_req", 32'(o_sdram_vid_req), 32'd0);
    check("rst_addr", 32'(o_sdram_vid_addr), 32'd0);
    check("rst_rd_data", 32'(o_rd_data), 32'd0);

    // Basic fetch into bank1 with back-to-back ready pulses.
    ctl_gaps = 0; ctl_hold = 1; rd_random = 0;
    ctl_data_q.push_back(16'hA1B2); ctl_data_q.push_back(16'hC3D4);
    ctl_data_q.push_back(16'hE5F6); ctl_data_q.push_back(16'h0718);
    ctl_addr_q.delete();
    r0 = ctl_readies;
    start_fetch(25'h000100, 6'd2);
    check("basic_busy_t1", 32'(o_fetch_busy), 32'd1);
    check("basic_req_t1", 32'(o_sdram_vid_req), 32'd1);
    wait_done(100, "basic_done");
    check("basic_readies", 32'(ctl_readies - r0), 32'd4);
    check("basic_nreq", 32'(ctl_addr_q.size()), 32'd2);
    check("basic_addr0", 32'(ctl_addr_q[0]), 32'h100);
    check("basic_addr1", 32'(ctl_addr_q[1]), 32'h104);
    check("basic_busy_end", 32'(o_fetch_busy), 32'd0);
    i_swap = 1'b1;
    tick();
    exp_b = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h18, 8'h07};
    for (int i = 0; i < 8; i++) begin
      i_rd_addr = 8'(i);
      tick();
      check($sformatf("basic_byte%0d", i), 32'(o_rd_data), 32'(exp_b[i]));
    end
    i_rd_addr = 8'd200;
    tick();
    check("rd_out_of_range", 32'(o_rd_data), 32'd0);

    // Request gating with ack held for three cycles.
    ctl_hold = 3;
    r0 = ctl_reads; d0 = ctl_dups;
    start_fetch(25'h0ABCDE, 6'd3);
    wait_done(200, "gate_done");
    check("gate_reads", 32'(ctl_reads - r0), 32'd3);
    check("gate_dups", 32'(ctl_dups - d0), 32'd0);
    ctl_hold = 1;

    // Empty fetch.
    r0 = ctl_reads;
    start_fetch(25'h000200, 6'd0);
    check("empty_done", 32'(o_fetch_done), 32'd1);
    check("empty_busy", 32'(o_fetch_busy), 32'd0);
    check("empty_req", 32'(o_sdram_vid_req), 32'd0);
    tick();
    tick();
    check("empty_done_pulse", 32'(o_fetch_done), 32'd0);
    check("empty_reads", 32'(ctl_reads - r0), 32'd0);

    // Odd start address.
    start_fetch(25'h000101, 6'd1);
    check("odd_addr", 32'(o_sdram_vid_addr), 32'h100);
    wait_done(100, "odd_done");

    // Double buffering: line X displayed, line Y fetched behind it.
    ctl_gaps = 1;
    ctl_data_q.push_back(16'h3C11);
    start_fetch(25'h001000, 6'd4);
    wait_done(200, "x_done");
    i_swap = 1'b1;
    tick();
    rd_random = 1;
    ctl_data_q.push_back(16'h5A22);
    start_fetch(25'h002000, 6'd6);
    k = 0;
    while (m_stored < 6 && k < 200) begin
      tick();
      k++;
    end
    check("dbuf_progress", 32'(m_stored >= 6), 32'd1);
    rd_random = 0;
    i_rd_addr = 8'd1;
    tick();
    check("dbuf_x_byte1", 32'(o_rd_data), 32'h3C);
    i_swap = 1'b1;
    rd_random = 1;
    tick();
    wait_done(300, "y_done");
    rd_random = 0;
    i_rd_addr = 8'd0;
    tick();
    check("dbuf_y_byte0", 32'(o_rd_data), 32'h22);

    // Clamp, address wrap, and a fetch_go while busy.
    r0 = ctl_reads;
    rd_random = 1;
    start_fetch(25'h1FFFF80, 6'd63);
    for (int i = 0; i < 5; i++) tick();
    i_fetch_go = 1'b1;
    i_fetch_addr = 25'h000333;
    i_fetch_pairs = 6'd5;
    tick();
    wait_done(1000, "clamp_done");
    check("clamp_reads", 32'(ctl_reads - r0), 32'd40);

    // Reset between the two words of a pair, then stray ready pulses.
    start_fetch(25'h004000, 6'd4);
    k = 0;
    while (m_stored % 2 == 0 && k < 200) begin
      tick();
      k++;
    end
    check("mid_found", 32'(m_stored % 2), 32'd1);
    i_init = 1'b1;
    tick();
    ctl_ack_left = 0; ctl_words_due = 0; ctl_req_seen = 0;
    check("mid_req", 32'(o_sdram_vid_req), 32'd0);
    check("mid_busy", 32'(o_fetch_busy), 32'd0);
    i_sdram_vid_ready = 1'b1;
    i_sdram_dout = 16'hDEAD;
    tick();
    i_sdram_vid_ready = 1'b1;
    tick();
    check("stray_busy", 32'(o_fetch_busy), 32'd0);
    check("stray_done", 32'(o_fetch_done), 32'd0);
    start_fetch(25'h000500, 6'd2);
    wait_done(200, "after_init_done");

    // Randomized fetches with random holds, gaps, swaps and reads.
    swap_random = 1;
    for (int n = 0; n < 25; n++) begin
      ctl_hold = $urandom_range(1, 3);
      start_fetch(25'($urandom), 6'($urandom_range(0, 63)));
      wait_done(1500, "rand_done");
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end
    swap_random = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
